// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - colour-depth codes and per-depth decode helpers for the address generator
package gfx_pkg;

  typedef enum logic [3:0] {
    BPP1  = 4'd0,
    BPP2  = 4'd1,
    BPP4  = 4'd2,
    BPP8  = 4'd3,
    BPP16 = 4'd4,
    BPP24 = 4'd5,
    BPP32 = 4'd6
  } gfx_depth_e;

  // Storage bits per pixel; unknown codes behave as BPP16.
  function automatic int bpp_f(input logic [3:0] d);
    case (d)
      BPP1:    return 1;
      BPP2:    return 2;
      BPP4:    return 4;
      BPP8:    return 8;
      BPP24:   return 24;
      BPP32:   return 32;
      default: return 16;
    endcase
  endfunction

  // Significant colour bits inside one stored pixel.
  function automatic int cbpp_f(input logic [3:0] d);
    case (d)
      BPP1:    return 1;
      BPP2:    return 2;
      BPP4:    return 3;
      BPP8:    return 5;
      BPP24:   return 18;
      BPP32:   return 24;
      default: return 12;
    endcase
  endfunction

  function automatic logic [5:0] bpp_m1(input logic [3:0] d);
    return 6'(bpp_f(d) - 1);
  endfunction

  function automatic logic [5:0] cbpp_m1(input logic [3:0] d);
    return 6'(cbpp_f(d) - 1);
  endfunction

  // Fixed-point pixels-to-strips factor: 65536*bpp/SW.
  function automatic logic [15:0] coeff_f(input int sw, input logic [3:0] d);
    return 16'((65536 * bpp_f(d)) / sw);
  endfunction

  // Bits of a strip actually filled by whole pixels (non power-of-two depths leave a gap).
  function automatic logic [9:0] coeff2_f(input int sw, input logic [3:0] d);
    return 10'(sw - (sw % bpp_f(d)));
  endfunction

endpackage

// File: rtl/gfx_addr_gen_pipe_if.sv
// rtl/gfx_addr_gen_pipe_if.sv - request/result handshake bundle of the pixel-address generator
interface gfx_addr_gen_pipe_if #(
  parameter int SW = 128,
  parameter int AW = 32,
  parameter int CW = 16,
  parameter int TW = 8
);
  localparam int MW = $clog2(SW) + 1;

  logic          in_valid_i;
  logic          in_ready_o;
  logic [AW-1:0] base_addr_i;
  logic [3:0]    color_depth_i;
  logic [CW-1:0] bmp_width_i;
  logic [CW-1:0] bmp_height_i;
  logic [CW-1:0] x_i;
  logic [CW-1:0] y_i;
  logic [TW-1:0] tag_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [AW-1:0] address_o;
  logic [MW-1:0] mb_o;
  logic [MW-1:0] me_o;
  logic [MW-1:0] ce_o;
  logic          clip_o;
  logic [TW-1:0] tag_o;

  modport master (
    output in_valid_i, base_addr_i, color_depth_i, bmp_width_i, bmp_height_i,
           x_i, y_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, address_o, mb_o, me_o, ce_o, clip_o, tag_o
  );

  modport slave (
    input  in_valid_i, base_addr_i, color_depth_i, bmp_width_i, bmp_height_i,
           x_i, y_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, address_o, mb_o, me_o, ce_o, clip_o, tag_o
  );
endinterface

// File: rtl/gfx_depth_decode.sv
// rtl/gfx_depth_decode.sv - combinational colour-depth code to multiplier constants
module gfx_depth_decode
  import gfx_pkg::*;
#(
  parameter int SW = 128
) (
  input  logic [3:0]  color_depth_i,
  output logic [15:0] coeff_o,
  output logic [5:0]  bpp_m1_o,
  output logic [5:0]  cbpp_m1_o,
  output logic [9:0]  coeff2_o
);

  assign coeff_o   = coeff_f(SW, color_depth_i);
  assign bpp_m1_o  = bpp_m1(color_depth_i);
  assign cbpp_m1_o = cbpp_m1(color_depth_i);
  assign coeff2_o  = coeff2_f(SW, color_depth_i);

endmodule

// File: rtl/gfx_addr_gen_pipe.sv
// rtl/gfx_addr_gen_pipe.sv - 3-stage pixel-address pipeline; clip logic under GFX_CALC_CLIP_EN
module gfx_addr_gen_pipe
  import gfx_pkg::*;
#(
  parameter int SW = 128,
  parameter int AW = 32,
  parameter int CW = 16,
  parameter int TW = 8
) (
  input logic               clk,
  input logic               rst_ni,
  gfx_addr_gen_pipe_if.slave bus
);

  localparam int MW = $clog2(SW) + 1;
  localparam int SH = $clog2(SW / 8);

  // Stage occupancy and elastic handshake chain.
  logic s1_v_q, s2_v_q, s3_v_q;
  logic s3_free, s2_adv, s2_free, s1_adv, s1_free, in_fire;

  assign s3_free = !s3_v_q || bus.out_ready_i;
  assign s2_adv  = s2_v_q && s3_free;
  assign s2_free = !s2_v_q || s2_adv;
  assign s1_adv  = s1_v_q && s2_free;
  assign s1_free = !s1_v_q || s1_adv;
  assign in_fire = bus.in_valid_i && s1_free;

  assign bus.in_ready_o = s1_free;

  // S1 next-state: latch request and its decoded depth constants.
  logic [15:0] dec_coeff;
  logic [5:0]  dec_bpp_m1, dec_cbpp_m1;
  logic [9:0]  dec_coeff2;
  logic        s1_clip_d;

  gfx_depth_decode #(.SW(SW)) u_dec (
    .color_depth_i (bus.color_depth_i),
    .coeff_o       (dec_coeff),
    .bpp_m1_o      (dec_bpp_m1),
    .cbpp_m1_o     (dec_cbpp_m1),
    .coeff2_o      (dec_coeff2)
  );

`ifdef GFX_CALC_CLIP_EN
  assign s1_clip_d = (bus.x_i >= bus.bmp_width_i) || (bus.y_i >= bus.bmp_height_i);
`else
  logic unused_height;
  assign unused_height = ^bus.bmp_height_i;
  assign s1_clip_d     = 1'b0;
`endif

  logic [AW-1:0] s1_base_q;
  logic [CW-1:0] s1_x_q, s1_y_q, s1_w_q;
  logic [15:0]   s1_coeff_q;
  logic [5:0]    s1_bpp_m1_q, s1_cbpp_m1_q;
  logic [9:0]    s1_coeff2_q;
  logic [TW-1:0] s1_tag_q;
  logic          s1_clip_q;

  // S2 next-state: the two coordinate multiplies and the rounded fraction.
  logic [31:0] sn65_d, ns65_d;
  logic [15:0] fr_d;
  logic        unused_lo;

  assign sn65_d    = 32'(s1_x_q) * 32'(s1_coeff_q);
  assign ns65_d    = 32'(s1_w_q) * 32'(s1_coeff_q);
  assign fr_d      = sn65_d[15:0] + 16'h7F;
  assign unused_lo = ^{ns65_d[15:0], fr_d[6:0]};

  logic [AW-1:0] s2_base_q;
  logic [CW-1:0] s2_y_q;
  logic [15:0]   s2_sn_hi_q, s2_ns_hi_q;
  logic [8:0]    s2_frh_q;
  logic [5:0]    s2_bpp_m1_q, s2_cbpp_m1_q;
  logic [9:0]    s2_coeff2_q;
  logic [TW-1:0] s2_tag_q;
  logic          s2_clip_q;

  // S3 next-state: bit positions and strip address; clipped pixels collapse to base.
  logic [18:0]   mb_prod;
  logic [63:0]   strip_off;
  logic [MW-1:0] mb_d, me_d, ce_d;
  logic [AW-1:0] addr_d;

  always_comb begin
    mb_prod   = 19'(s2_frh_q) * 19'(s2_coeff2_q);
    strip_off = 64'(s2_ns_hi_q) * 64'(s2_y_q) + 64'(s2_sn_hi_q);
    mb_d      = MW'(mb_prod >> 9);
    me_d      = mb_d + MW'(s2_bpp_m1_q);
    ce_d      = mb_d + MW'(s2_cbpp_m1_q);
    addr_d    = s2_base_q + AW'(strip_off << SH);
    if (s2_clip_q) begin
      mb_d   = '0;
      me_d   = '0;
      ce_d   = '0;
      addr_d = s2_base_q;
    end
  end

  logic [AW-1:0] s3_addr_q;
  logic [MW-1:0] s3_mb_q, s3_me_q, s3_ce_q;
  logic [TW-1:0] s3_tag_q;
  logic          s3_clip_q;

  // Stage valid flags; async reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
    end else begin
      if (s1_free) s1_v_q <= bus.in_valid_i;
      if (s2_free) s2_v_q <= s1_v_q;
      if (s3_free) s3_v_q <= s2_v_q;
    end
  end

  // S1 payload, loaded only on an accepted request.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_base_q    <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_w_q       <= '0;
      s1_coeff_q   <= '0;
      s1_bpp_m1_q  <= '0;
      s1_cbpp_m1_q <= '0;
      s1_coeff2_q  <= '0;
      s1_tag_q     <= '0;
      s1_clip_q    <= 1'b0;
    end else if (in_fire) begin
      s1_base_q    <= bus.base_addr_i;
      s1_x_q       <= bus.x_i;
      s1_y_q       <= bus.y_i;
      s1_w_q       <= bus.bmp_width_i;
      s1_coeff_q   <= dec_coeff;
      s1_bpp_m1_q  <= dec_bpp_m1;
      s1_cbpp_m1_q <= dec_cbpp_m1;
      s1_coeff2_q  <= dec_coeff2;
      s1_tag_q     <= bus.tag_i;
      s1_clip_q    <= s1_clip_d;
    end
  end

  // S2 payload, loaded when S1 hands over.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_base_q    <= '0;
      s2_y_q       <= '0;
      s2_sn_hi_q   <= '0;
      s2_ns_hi_q   <= '0;
      s2_frh_q     <= '0;
      s2_bpp_m1_q  <= '0;
      s2_cbpp_m1_q <= '0;
      s2_coeff2_q  <= '0;
      s2_tag_q     <= '0;
      s2_clip_q    <= 1'b0;
    end else if (s1_adv) begin
      s2_base_q    <= s1_base_q;
      s2_y_q       <= s1_y_q;
      s2_sn_hi_q   <= sn65_d[31:16];
      s2_ns_hi_q   <= ns65_d[31:16];
      s2_frh_q     <= fr_d[15:7];
      s2_bpp_m1_q  <= s1_bpp_m1_q;
      s2_cbpp_m1_q <= s1_cbpp_m1_q;
      s2_coeff2_q  <= s1_coeff2_q;
      s2_tag_q     <= s1_tag_q;
      s2_clip_q    <= s1_clip_q;
    end
  end

  // S3 result registers; held while stalled or empty.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      s3_addr_q <= '0;
      s3_mb_q   <= '0;
      s3_me_q   <= '0;
      s3_ce_q   <= '0;
      s3_tag_q  <= '0;
      s3_clip_q <= 1'b0;
    end else if (s2_adv) begin
      s3_addr_q <= addr_d;
      s3_mb_q   <= mb_d;
      s3_me_q   <= me_d;
      s3_ce_q   <= ce_d;
      s3_tag_q  <= s2_tag_q;
      s3_clip_q <= s2_clip_q;
    end
  end

  assign bus.out_valid_o = s3_v_q;
  assign bus.address_o   = s3_addr_q;
  assign bus.mb_o        = s3_mb_q;
  assign bus.me_o        = s3_me_q;
  assign bus.ce_o        = s3_ce_q;
  assign bus.tag_o       = s3_tag_q;
  assign bus.clip_o      = s3_clip_q;

endmodule

// File: tb/tb_gfx_addr_gen_pipe.sv
// tb/tb_gfx_addr_gen_pipe.sv - randomized scoreboard bench for gfx_addr_gen_pipe (SW=128)
module tb_gfx_addr_gen_pipe;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  gfx_addr_gen_pipe_if #(.SW(128), .AW(32), .CW(16), .TW(8)) bus ();

  gfx_addr_gen_pipe #(.SW(128), .AW(32), .CW(16), .TW(8)) dut (
    .clk    (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  mb, me, ce, tag;
    logic        clip;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, n_out = 0, first_fire = -1, last_fire = -1;
  bit chk_lat = 1'b0, head_seen = 1'b0, last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference: pixel -> strip index and bit offset, straight from the arithmetic rules.
  function automatic exp_t model(input logic [3:0] d, input logic [31:0] base,
                                 input int w, input int h, input int x, input int y,
                                 input logic [7:0] tag);
    exp_t e;
    int bpp, cbpp;
    longint coeff, sn, ns, fr, mb, off;
    case (d)
      4'd0: begin bpp = 1;  cbpp = 1;  end
      4'd1: begin bpp = 2;  cbpp = 2;  end
      4'd2: begin bpp = 4;  cbpp = 3;  end
      4'd3: begin bpp = 8;  cbpp = 5;  end
      4'd5: begin bpp = 24; cbpp = 18; end
      4'd6: begin bpp = 32; cbpp = 24; end
      default: begin bpp = 16; cbpp = 12; end
    endcase
    coeff = (longint'(65536) * bpp) / 128;
    sn    = x * coeff;
    ns    = w * coeff;
    fr    = ((sn % 65536) + 127) % 65536;
    mb    = ((fr / 128) * (128 - (128 % bpp))) / 512;
    off   = (ns / 65536) * y + (sn / 65536);
    e.addr = 32'(longint'(base) + off * 16);
    e.mb   = 8'(mb);
    e.me   = 8'(mb + bpp - 1);
    e.ce   = 8'(mb + cbpp - 1);
    e.tag  = tag;
    e.clip = 1'b0;
    e.acc_cyc = 0;
`ifdef GFX_CALC_CLIP_EN
    if (x >= w || y >= h) begin
      e.clip = 1'b1;
      e.addr = base;
      e.mb = 8'd0; e.me = 8'd0; e.ce = 8'd0;
    end
`endif
    return e;
  endfunction

  task automatic set_req(input logic [3:0] d, input logic [31:0] base, input int w,
                         input int h, input int x, input int y, input logic [7:0] tag);
    bus.in_valid_i    = 1'b1;
    bus.color_depth_i = d;
    bus.base_addr_i   = base;
    bus.bmp_width_i   = 16'(w);
    bus.bmp_height_i  = 16'(h);
    bus.x_i           = 16'(x);
    bus.y_i           = 16'(y);
    bus.tag_i         = tag;
  endtask

  task automatic rand_req(input logic [7:0] tag);
    set_req(4'($urandom_range(0, 15)), $urandom, $urandom_range(1, 2047),
            $urandom_range(1, 2047), $urandom_range(0, 2100), $urandom_range(0, 2100), tag);
  endtask

  // One clock: sample at negedge+1, score outputs, record handshakes, advance.
  task automatic step();
    exp_t e;
    #1;
    if (bus.out_valid_o) begin
      if (q.size() == 0) begin
        check("spurious_valid", bus.out_valid_o, 1'b0);
      end else begin
        check("address", bus.address_o, q[0].addr);
        check("mb", bus.mb_o, q[0].mb);
        check("me", bus.me_o, q[0].me);
        check("ce", bus.ce_o, q[0].ce);
        check("clip", bus.clip_o, q[0].clip);
        check("tag", bus.tag_o, q[0].tag);
        if (chk_lat && !head_seen) check("latency", 64'(cyc - q[0].acc_cyc), 64'd3);
        head_seen = 1'b1;
      end
    end
    if (bus.out_valid_o && bus.out_ready_i && q.size() > 0) begin
      void'(q.pop_front());
      head_seen = 1'b0;
      n_out++;
      if (first_fire < 0) first_fire = cyc;
      last_fire = cyc;
    end
    last_acc = bus.in_valid_i && bus.in_ready_o;
    if (last_acc) begin
      e = model(bus.color_depth_i, bus.base_addr_i, int'(bus.bmp_width_i),
                int'(bus.bmp_height_i), int'(bus.x_i), int'(bus.y_i), bus.tag_i);
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 40 && (q.size() > 0 || bus.out_valid_o); i++) step();
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 10 && !bus.out_valid_o; i++) step();
    check("valid_seen", bus.out_valid_o, 1'b1);
  endtask

  initial begin
    int acc;
    rst_ni = 1'b0;
    bus.out_ready_i = 1'b0;
    set_req(4'd0, 32'd0, 0, 0, 0, 0, 8'd0);
    bus.in_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check("rst_valid", bus.out_valid_o, 1'b0);
    check("rst_addr", bus.address_o, 32'd0);
    check("rst_mb", bus.mb_o, 8'd0);
    check("rst_me", bus.me_o, 8'd0);
    check("rst_ce", bus.ce_o, 8'd0);
    check("rst_clip", bus.clip_o, 1'b0);
    check("rst_tag", bus.tag_o, 8'd0);
    check("rst_ready", bus.in_ready_o, 1'b1);
    @(negedge clk);

    // Directed BPP16 and BPP8 points.
    chk_lat = 1'b1;
    bus.out_ready_i = 1'b1;
    set_req(4'd4, 32'h1000, 640, 480, 9, 2, 8'hA1);
    step();
    bus.in_valid_i = 1'b0;
    wait_valid();
    check("t1_addr", bus.address_o, 32'h1A10);
    check("t1_mb", bus.mb_o, 8'd16);
    check("t1_me", bus.me_o, 8'd31);
    check("t1_ce", bus.ce_o, 8'd27);
    step();
    set_req(4'd3, 32'h2000, 640, 480, 0, 0, 8'hA2);
    step();
    bus.in_valid_i = 1'b0;
    wait_valid();
    check("t2_addr", bus.address_o, 32'h2000);
    check("t2_mb", bus.mb_o, 8'd0);
    check("t2_me", bus.me_o, 8'd7);
    check("t2_ce", bus.ce_o, 8'd4);
    drain();

    // Eight back-to-back requests at full rate.
    first_fire = -1;
    acc = n_out;
    for (int i = 0; i < 8; i++) begin
      rand_req(8'(i));
      step();
      check("t3_accept", last_acc, 1'b1);
    end
    drain();
    check("t3_count", 64'(n_out - acc), 64'd8);
    check("t3_consec", 64'(last_fire - first_fire), 64'd7);

    // Output stalled for 5 clocks while the source keeps pushing.
    chk_lat = 1'b0;
    bus.out_ready_i = 1'b0;
    acc = 0;
    rand_req(8'h40);
    for (int i = 0; i < 5; i++) begin
      step();
      if (last_acc) begin
        acc++;
        rand_req(8'(8'h40 + acc));
      end
    end
    check("t4_accepts", 64'(acc), 64'd3);
    #1;
    check("t4_full_ready", bus.in_ready_o, 1'b0);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (last_acc) rand_req(8'($urandom));
    end
    drain();

    // Async reset with requests in flight.
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_req(8'(8'h60 + i));
      step();
    end
    bus.in_valid_i = 1'b0;
    wait_valid();
    rst_ni = 1'b0;
    #1;
    check("t5_rst_valid", bus.out_valid_o, 1'b0);
    check("t5_rst_addr", bus.address_o, 32'd0);
    q.delete();
    head_seen = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_stale", bus.out_valid_o, 1'b0);
    end

`ifdef GFX_CALC_CLIP_EN
    set_req(4'd4, 32'h3000, 640, 480, 640, 0, 8'h70);
    step();
    bus.in_valid_i = 1'b0;
    wait_valid();
    check("t6_clip", bus.clip_o, 1'b1);
    check("t6_addr", bus.address_o, 32'h3000);
    step();
    set_req(4'd4, 32'h3000, 640, 480, 639, 479, 8'h71);
    step();
    bus.in_valid_i = 1'b0;
    wait_valid();
    check("t6_noclip", bus.clip_o, 1'b0);
    drain();
`endif

    // Random traffic with random back-pressure.
    last_acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(bus.in_valid_i && !last_acc)) begin
        if ($urandom_range(0, 9) < 7) rand_req(8'($urandom));
        else bus.in_valid_i = 1'b0;
      end
      bus.out_ready_i = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
